// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues ROM words to execute over valid/ready,
// resolves JMP locally and stalls on BLE until execute reports the outcome.
module instruction_fetch_sequencer #(
  parameter logic [7:0]  OPC_JMP  = 8'd7,
  parameter logic [7:0]  OPC_BLE  = 8'd5,
  parameter logic [15:0] RESET_PC = 16'd0
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  output logic [27:0] oInstruction,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iBranchValid,
  input  logic        iBranchTaken,
  input  logic        iHalt,
  output logic        oBranchPending,
  output logic [15:0] oIssueCount
);

  typedef enum logic {
    FETCH,
    WAIT_BR
  } state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] br_target, br_target_n;
  logic [15:0] br_fall, br_fall_n;
  logic [15:0] cnt;
  logic [27:0] ir, ir_n;
  logic        valid, valid_n;

  logic [7:0]  opcode;
  logic [15:0] target;
  logic        slot_free;
  logic        handshake;
  logic        is_jmp;
  logic        is_ble;

  assign opcode    = iInstruction[27:20];
  assign target    = {8'd0, iInstruction[23:16]};
  assign slot_free = !valid || iReady;
  assign handshake = valid && iReady;
  assign is_jmp    = (opcode == OPC_JMP);
  assign is_ble    = (opcode == OPC_BLE);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 28'd0;
      valid     <= 1'b0;
      br_target <= 16'd0;
      br_fall   <= 16'd0;
      cnt       <= 16'd0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      ir        <= ir_n;
      valid     <= valid_n;
      br_target <= br_target_n;
      br_fall   <= br_fall_n;
      cnt       <= cnt + {15'd0, handshake};
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ir_n        = ir;
    valid_n     = valid;
    br_target_n = br_target;
    br_fall_n   = br_fall;
    unique case (state)
      FETCH: begin
        if (slot_free && !iHalt) begin
          unique case (1'b1)
            is_jmp: begin
              // JMP is swallowed here and never reaches execute
              pc_n = target;
              if (iReady) valid_n = 1'b0;
            end
            is_ble: begin
              ir_n        = iInstruction;
              valid_n     = 1'b1;
              br_target_n = target;
              br_fall_n   = pc + 16'd1;
              state_n     = WAIT_BR;
            end
            default: begin
              ir_n    = iInstruction;
              valid_n = 1'b1;
              pc_n    = pc + 16'd1;
            end
          endcase
        end else if (handshake) begin
          valid_n = 1'b0;
        end
      end
      WAIT_BR: begin
        if (handshake) valid_n = 1'b0;
        // outcome only counts once the BLE itself has left the IR
        if (!valid && iBranchValid) begin
          pc_n    = iBranchTaken ? br_target : br_fall;
          state_n = FETCH;
        end
      end
    endcase
  end

  assign oAddress       = pc;
  assign oInstruction   = ir;
  assign oValid         = valid;
  assign oBranchPending = (state == WAIT_BR);
  assign oIssueCount    = cnt;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer: sequential fetch, JMP,
// BLE taken/not-taken, backpressure, halt, reset and RESET_PC wrap.
module tb_instruction_fetch_sequencer;

  localparam logic [7:0] JMP = 8'h10;
  localparam logic [7:0] BLE = 8'h20;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic [27:0] oInstruction;
  logic        oValid;
  logic        iReady;
  logic        iBranchValid;
  logic        iBranchTaken;
  logic        iHalt;
  logic        oBranchPending;
  logic [15:0] oIssueCount;

  logic [15:0] a2;
  logic [27:0] ins2;
  logic        v2;
  logic        bp2;
  logic [15:0] cnt2;

  logic [27:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  assign iInstruction = rom[oAddress[7:0]];

  instruction_fetch_sequencer #(
    .OPC_JMP (JMP),
    .OPC_BLE (BLE),
    .RESET_PC(16'd0)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .oInstruction  (oInstruction),
    .oValid        (oValid),
    .iReady        (iReady),
    .iBranchValid  (iBranchValid),
    .iBranchTaken  (iBranchTaken),
    .iHalt         (iHalt),
    .oBranchPending(oBranchPending),
    .oIssueCount   (oIssueCount)
  );

  instruction_fetch_sequencer #(
    .OPC_JMP (JMP),
    .OPC_BLE (BLE),
    .RESET_PC(16'hFFFF)
  ) dut_wrap (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (a2),
    .iInstruction  (28'd0),
    .oInstruction  (ins2),
    .oValid        (v2),
    .iReady        (1'b1),
    .iBranchValid  (1'b0),
    .iBranchTaken  (1'b0),
    .iHalt         (1'b0),
    .oBranchPending(bp2),
    .oIssueCount   (cnt2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic fill;
    for (int i = 0; i < 256; i++)
      rom[i] = {8'h03, 4'h0, 16'(16'h100 + i)};
    rom[0] = 28'd0;
  endtask

  task automatic do_reset;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("rst_addr", 32'(oAddress), 32'h0);
    check("rst_ir", 32'(oInstruction), 32'h0);
    check("rst_valid", 32'(oValid), 32'h0);
    check("rst_pend", 32'(oBranchPending), 32'h0);
    check("rst_cnt", 32'(oIssueCount), 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    iReady       = 1'b1;
    iHalt        = 1'b0;
    iBranchValid = 1'b0;
    iBranchTaken = 1'b0;
    fill();

    // sequential stream, plus the FFFF -> 0 wrap instance
    do_reset();
    check("wrap_rst", 32'(a2), 32'hFFFF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_addr", 32'(oAddress), 32'(i));
      check("seq_ir", 32'(oInstruction), 32'(rom[i-1]));
      check("seq_valid", 32'(oValid), 32'h1);
      check("seq_cnt", 32'(oIssueCount), 32'(i - 1));
      if (i == 1) begin
        check("wrap_addr", 32'(a2), 32'h0);
        check("wrap_valid", 32'(v2), 32'h1);
      end
    end
    tick();
    check("seq_cnt4", 32'(oIssueCount), 32'h4);

    // halt blocks fetch from an empty slot
    fill();
    iHalt = 1'b1;
    do_reset();
    tick();
    tick();
    check("halt_addr", 32'(oAddress), 32'h0);
    check("halt_valid", 32'(oValid), 32'h0);
    iHalt = 1'b0;
    tick();
    check("unhalt_addr", 32'(oAddress), 32'h1);
    check("unhalt_valid", 32'(oValid), 32'h1);

    // JMP at 14 to 2
    fill();
    rom[14] = {JMP, 4'h2, 16'h0};
    do_reset();
    repeat (14) tick();
    check("jmp_pre_addr", 32'(oAddress), 32'd14);
    check("jmp_pre_ir", 32'(oInstruction), 32'(rom[13]));
    tick();
    check("jmp_addr", 32'(oAddress), 32'd2);
    check("jmp_bubble", 32'(oValid), 32'h0);
    check("jmp_ir", 32'(oInstruction), 32'(rom[13]));
    check("jmp_cnt", 32'(oIssueCount), 32'd14);
    tick();
    check("jmp_tgt_valid", 32'(oValid), 32'h1);
    check("jmp_tgt_ir", 32'(oInstruction), 32'(rom[2]));
    check("jmp_tgt_addr", 32'(oAddress), 32'd3);

    // BLE at 9 to 8: taken, then not-taken with early and simultaneous pulses
    fill();
    rom[9] = {BLE, 4'h8, 16'h0};
    do_reset();
    repeat (10) tick();
    check("ble_addr", 32'(oAddress), 32'd9);
    check("ble_pend", 32'(oBranchPending), 32'h1);
    check("ble_ir", 32'(oInstruction), 32'(rom[9]));
    check("ble_valid", 32'(oValid), 32'h1);
    tick();
    check("ble_acc_valid", 32'(oValid), 32'h0);
    check("ble_acc_pend", 32'(oBranchPending), 32'h1);
    check("ble_acc_cnt", 32'(oIssueCount), 32'd10);
    tick();
    check("ble_hold_addr", 32'(oAddress), 32'd9);
    check("ble_hold_pend", 32'(oBranchPending), 32'h1);
    iBranchValid = 1'b1;
    iBranchTaken = 1'b1;
    tick();
    check("taken_addr", 32'(oAddress), 32'd8);
    check("taken_pend", 32'(oBranchPending), 32'h0);
    check("taken_valid", 32'(oValid), 32'h0);
    iBranchValid = 1'b0;
    tick();
    check("taken_ir", 32'(oInstruction), 32'(rom[8]));
    check("taken_valid2", 32'(oValid), 32'h1);
    check("taken_addr2", 32'(oAddress), 32'd9);
    tick();
    check("ble2_pend", 32'(oBranchPending), 32'h1);
    check("ble2_ir", 32'(oInstruction), 32'(rom[9]));
    iReady       = 1'b0;
    iBranchValid = 1'b1;
    iBranchTaken = 1'b0;
    tick();
    check("early_pend", 32'(oBranchPending), 32'h1);
    check("early_valid", 32'(oValid), 32'h1);
    check("early_addr", 32'(oAddress), 32'd9);
    iReady = 1'b1;
    tick();
    check("simul_valid", 32'(oValid), 32'h0);
    check("simul_pend", 32'(oBranchPending), 32'h1);
    check("simul_addr", 32'(oAddress), 32'd9);
    tick();
    check("fall_addr", 32'(oAddress), 32'd10);
    check("fall_pend", 32'(oBranchPending), 32'h0);
    iBranchValid = 1'b0;
    tick();
    check("fall_ir", 32'(oInstruction), 32'(rom[10]));
    check("fall_valid", 32'(oValid), 32'h1);
    check("fall_addr2", 32'(oAddress), 32'd11);

    // reset while waiting on a branch
    fill();
    rom[9] = {BLE, 4'h8, 16'h0};
    do_reset();
    repeat (10) tick();
    check("midbr_pend", 32'(oBranchPending), 32'h1);
    do_reset();

    // backpressure: hold five cycles, then exactly one issue
    fill();
    iReady = 1'b0;
    do_reset();
    tick();
    check("bp_addr", 32'(oAddress), 32'h1);
    check("bp_valid", 32'(oValid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_addr", 32'(oAddress), 32'h1);
      check("bp_hold_ir", 32'(oInstruction), 32'(rom[0]));
      check("bp_hold_cnt", 32'(oIssueCount), 32'h0);
    end
    iReady = 1'b1;
    tick();
    check("bp_rel_cnt", 32'(oIssueCount), 32'h1);
    check("bp_rel_ir", 32'(oInstruction), 32'(rom[1]));
    check("bp_rel_addr", 32'(oAddress), 32'h2);
    iReady = 1'b0;
    tick();
    check("bp_once_cnt", 32'(oIssueCount), 32'h1);
    check("bp_once_ir", 32'(oInstruction), 32'(rom[1]));
    check("bp_once_addr", 32'(oAddress), 32'h2);
    check("bp_once_valid", 32'(oValid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
